tbus_rr_arbiter: RTL

Round-robin arbiter that owns the one-hot select lines of the 8-source tristate bus multiplexer. Eight requesters share one single-bit tristate net; the block grants at most one requester at a time and drives the matching enable. It enforces a one-cycle all-off turnaround between owners, so no two drivers overlap on the net. It also caps each tenure so that no requester can starve the others.

---
 rtl/tbus_rr_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/tbus_rr_arbiter.sv
// tbus_rr_arbiter: round-robin owner of the one-hot tristate bus enables.
// Inserts one all-off turnaround cycle between owners and caps each tenure at MAX_HOLD cycles.
module tbus_rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         sel_o,
    output logic [$clog2(N)-1:0] gnt_id_o,
    output logic                 gnt_valid_o,
    output logic                 turn_o
);
    localparam int W  = $clog2(N);
    localparam int CW = $clog2(MAX_HOLD + 1);
    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;
    state_e         state_q;
    logic [N-1:0]   sel_q;
    logic [W-1:0]   gnt_id_q;
    logic [W-1:0]   ptr_q;
    logic [CW-1:0]  cnt_q;
    logic           gnt_valid_q;
    logic           turn_q;
    logic [W-1:0]   win_d;
    logic [W-1:0]   idx;
    logic           found;
    // N is a power of two, so the W-bit add wraps the search modulo N for free.
    always_comb begin
        win_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + W'(i);
            if (!found && req_i[idx]) begin
                win_d = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            gnt_id_q    <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            turn_q      <= 1'b0;
        end else begin
            case (state_q)
                GRANT: begin
                    if (!req_i[gnt_id_q] || cnt_q == CW'(MAX_HOLD)) begin
                        sel_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        turn_q      <= 1'b1;
                        ptr_q       <= gnt_id_q + W'(1);
                        state_q     <= TURN;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                IDLE, TURN: begin
                    turn_q <= 1'b0;
                    if (|req_i) begin
                        sel_q       <= N'(1) << win_d;
                        gnt_id_q    <= win_d;
                        gnt_valid_q <= 1'b1;
                        cnt_q       <= CW'(1);
                        state_q     <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign sel_o       = sel_q;
    assign gnt_id_o    = gnt_id_q;
    assign gnt_valid_o = gnt_valid_q;
    assign turn_o      = turn_q;
endmodule
